// File: rtl/mux_rr_arb.sv
// N-channel valid/ready multiplexer with round-robin or fixed-priority
// arbitration feeding a single registered output word.
//
// Ports:
//   clk, rst     rising-edge clock, async active-high reset
//   mode         0 = round-robin from r_ptr, 1 = fixed priority (ch0 first)
//   in_valid     per-channel valid
//   in_data      channel i in bits [i*WIDTH +: WIDTH]
//   in_ready     one-hot (or zero) accept strobe
//   out_valid    output register holds a word
//   out_data     registered selected word
//   out_ch       channel that supplied out_data
//   out_ready    consumer accepts the held word
module mux_rr_arb #(
   parameter  int N_CH  = 4,
   parameter  int WIDTH = 8,
   localparam int CH_W  = $clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mode,
   input  logic [N_CH-1:0]       in_valid,
   input  logic [N_CH*WIDTH-1:0] in_data,
   output logic [N_CH-1:0]       in_ready,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_data,
   output logic [CH_W-1:0]       out_ch,
   input  logic                  out_ready
);

   logic [CH_W-1:0]  r_ptr;
   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic [CH_W-1:0]  r_ch;

   logic [N_CH-1:0]  w_grant;
   logic             w_any;
   logic [CH_W-1:0]  w_idx;
   logic             w_load;
   logic             w_xfer;

   // Scan channels in priority order. In round-robin mode the order
   // starts at r_ptr and wraps; in fixed mode it starts at 0.
   always_comb begin
      logic [CH_W:0]   v_pos;
      logic [CH_W-1:0] v_ch;
      w_grant = '0;
      w_any   = 1'b0;
      w_idx   = '0;
      v_pos   = '0;
      v_ch    = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (mode) begin
            v_pos = (CH_W+1)'(k);
         end else begin
            v_pos = {1'b0, r_ptr} + (CH_W+1)'(k);
         end
         if (v_pos >= (CH_W+1)'(N_CH)) begin
            v_pos = v_pos - (CH_W+1)'(N_CH);
         end
         v_ch = v_pos[CH_W-1:0];
         if (!w_any && in_valid[v_ch]) begin
            w_any          = 1'b1;
            w_grant[v_ch]  = 1'b1;
            w_idx          = v_ch;
         end
      end
   end

   // Reset is gated in so no producer sees an accept while held in reset.
   assign w_load   = (!r_valid || out_ready) && !rst;
   assign w_xfer   = w_any && w_load;
   assign in_ready = w_grant & {N_CH{w_load}};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_ch    <= '0;
         r_ptr   <= '0;
      end else if (w_xfer) begin
         r_valid <= 1'b1;
         r_data  <= in_data[int'(w_idx)*WIDTH +: WIDTH];
         r_ch    <= w_idx;
         if (w_idx == CH_W'(N_CH-1)) begin
            r_ptr <= '0;
         end else begin
            r_ptr <= w_idx + 1'b1;
         end
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_ch    = r_ch;

endmodule

// File: tb/tb_mux_rr_arb.sv
// Self-checking bench for mux_rr_arb: directed scenarios plus a
// randomized run against a distance-based arbitration model.
module tb_mux_rr_arb;

   localparam int N = 4;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         mode;
   logic [N-1:0] in_valid;
   logic [N*W-1:0] in_data;
   logic [N-1:0] in_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic [1:0]   out_ch;
   logic         out_ready;

   logic [W-1:0] hd [N];

   int n_tests = 0;
   int n_fail  = 0;

   // reference state
   logic         m_valid;
   logic [W-1:0] m_data;
   int           m_ch;
   int           m_ptr;

   always #5 clk = ~clk;

   always_comb begin
      in_data = '0;
      for (int i = 0; i < N; i++) in_data[i*W +: W] = hd[i];
   end

   mux_rr_arb #(.N_CH(N), .WIDTH(W)) dut (
      .clk(clk), .rst(rst), .mode(mode),
      .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid),
      .out_data(out_data), .out_ch(out_ch),
      .out_ready(out_ready)
   );

   // Winner = valid channel with the smallest priority distance.
   function automatic logic [N-1:0] m_grant(input logic md,
                                            input logic [N-1:0] v,
                                            input int p);
      int best, bestd, d;
      best = -1;
      bestd = N;
      for (int i = 0; i < N; i++) begin
         if (v[i]) begin
            d = md ? i : (i - p + N) % N;
            if (d < bestd) begin bestd = d; best = i; end
         end
      end
      return (best < 0) ? '0 : N'(1 << best);
   endfunction

   function automatic logic [N-1:0] m_ready();
      if (rst || (m_valid && !out_ready)) return '0;
      return m_grant(mode, in_valid, m_ptr);
   endfunction

   task automatic m_reset();
      m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
   endtask

   task automatic tick(output int acc);
      logic [N-1:0] g;
      g = m_ready();
      acc = -1;
      @(posedge clk);
      for (int i = 0; i < N; i++) if (g[i]) acc = i;
      if (acc >= 0) begin
         m_valid = 1'b1; m_data = hd[acc]; m_ch = acc;
         m_ptr = (acc + 1) % N;
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      int a;
      mode = 0; in_valid = 4'b0100; hd[2] = 8'h77; out_ready = 0;
      #1; tick(a);
      n_tests++;
      if (out_valid !== 1'b1) begin n_fail++;
         $display("FAIL rst_pre out_valid got %b want 1", out_valid); end
      #2; rst = 1; #1;
      n_tests++;
      if ({out_valid, out_data, out_ch} !== 11'd0) begin n_fail++;
         $display("FAIL rst_async got v=%b d=%h c=%0d want 0 0 0",
                  out_valid, out_data, out_ch); end
      n_tests++;
      if (in_ready !== 4'b0000) begin n_fail++;
         $display("FAIL rst_ready got %b want 0000", in_ready); end
      m_reset();
      @(negedge clk); rst = 0;
      in_valid = 4'b1111; out_ready = 1; #1;
      n_tests++;
      if (in_ready !== 4'b0001) begin n_fail++;
         $display("FAIL rst_ptr got %b want 0001", in_ready); end
      tick(a);
      n_tests++;
      if (out_ch !== 2'd0 || out_valid !== 1'b1) begin n_fail++;
         $display("FAIL rst_first got ch=%0d v=%b want 0 1", out_ch, out_valid); end
      in_valid = 0; tick(a);
   endtask

   task automatic test_single();
      int a;
      mode = 0; in_valid = 4'b0100; hd[2] = 8'hA5; out_ready = 1; #1;
      n_tests++;
      if (in_ready !== 4'b0100) begin n_fail++;
         $display("FAIL single_ready got %b want 0100", in_ready); end
      tick(a);
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
         n_fail++;
         $display("FAIL single_out got v=%b d=%h c=%0d want 1 a5 2",
                  out_valid, out_data, out_ch); end
      in_valid = 0; tick(a);
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++;
         $display("FAIL single_drain got %b want 0", out_valid); end
   endtask

   task automatic test_rr_fair();
      int a;
      mode = 0; out_ready = 1;
      in_valid = 4'b1000; tick(a);
      for (int i = 0; i < N; i++) hd[i] = W'(8'h10 + i);
      in_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         #1;
         n_tests++;
         if (in_ready !== 4'(1 << (k % 4))) begin n_fail++;
            $display("FAIL rr_ready[%0d] got %b want ch%0d", k, in_ready, k % 4); end
         tick(a);
         n_tests++;
         if (out_valid !== 1'b1 || out_ch !== 2'(k % 4) ||
             out_data !== W'(8'h10 + k % 4)) begin n_fail++;
            $display("FAIL rr_out[%0d] got v=%b c=%0d d=%h want 1 %0d %h",
                     k, out_valid, out_ch, out_data, k % 4, 8'h10 + k % 4); end
      end
   endtask

   task automatic test_fixed();
      int a;
      mode = 1; in_valid = 4'b1010; out_ready = 1;
      hd[1] = 8'h5A; hd[3] = 8'hC3;
      for (int k = 0; k < 6; k++) begin
         #1;
         n_tests++;
         if (in_ready !== 4'b0010) begin n_fail++;
            $display("FAIL fixed_ready[%0d] got %b want 0010", k, in_ready); end
         tick(a);
         n_tests++;
         if (out_ch !== 2'd1 || out_data !== 8'h5A) begin n_fail++;
            $display("FAIL fixed_out[%0d] got c=%0d d=%h want 1 5a",
                     k, out_ch, out_data); end
      end
      mode = 0;
   endtask

   task automatic test_backpressure();
      int a;
      mode = 0; in_valid = 4'b0001; hd[0] = 8'h3C; out_ready = 1;
      tick(a);
      in_valid = 4'b1111; out_ready = 0;
      hd[1] = 8'hB1; hd[2] = 8'hB2; hd[3] = 8'hB3;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_tests++;
         if (in_ready !== 4'b0000) begin n_fail++;
            $display("FAIL bp_ready[%0d] got %b want 0000", k, in_ready); end
         tick(a);
         n_tests++;
         if (out_valid !== 1'b1 || out_data !== 8'h3C || out_ch !== 2'd0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d] got v=%b d=%h c=%0d want 1 3c 0",
                     k, out_valid, out_data, out_ch); end
      end
      out_ready = 1; #1;
      n_tests++;
      if (in_ready !== 4'b0010) begin n_fail++;
         $display("FAIL bp_release got %b want 0010", in_ready); end
      tick(a);
      n_tests++;
      if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'hB1) begin
         n_fail++;
         $display("FAIL bp_load got v=%b c=%0d d=%h want 1 1 b1",
                  out_valid, out_ch, out_data); end
   endtask

   task automatic test_wrap();
      int a;
      mode = 0; out_ready = 1; in_valid = 4'b0100; tick(a);
      in_valid = 4'b0011; #1;
      n_tests++;
      if (in_ready !== 4'b0001) begin n_fail++;
         $display("FAIL wrap_ch0 got %b want 0001", in_ready); end
      tick(a);
      n_tests++;
      if (out_ch !== 2'd0) begin n_fail++;
         $display("FAIL wrap_out0 got %0d want 0", out_ch); end
      n_tests++;
      if (in_ready !== 4'b0010) begin n_fail++;
         $display("FAIL wrap_ch1 got %b want 0010", in_ready); end
      tick(a);
      n_tests++;
      if (out_ch !== 2'd1) begin n_fail++;
         $display("FAIL wrap_out1 got %0d want 1", out_ch); end
      in_valid = 0; tick(a);
   endtask

   task automatic test_random();
      int a;
      logic [N-1:0] hv;
      hv = '0;
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!hv[i] && ($urandom_range(0, 2) != 0)) begin
               hv[i] = 1'b1; hd[i] = W'($urandom);
            end
         end
         in_valid = hv;
         mode = ($urandom_range(0, 7) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         n_tests++;
         if (in_ready !== m_ready()) begin n_fail++;
            $display("FAIL rnd_ready[%0d] got %b want %b", k, in_ready, m_ready()); end
         tick(a);
         if (a >= 0) hv[a] = 1'b0;
         n_tests++;
         if (out_valid !== m_valid ||
             (m_valid && (out_data !== m_data || out_ch !== 2'(m_ch)))) begin
            n_fail++;
            $display("FAIL rnd_out[%0d] got v=%b d=%h c=%0d want %b %h %0d",
                     k, out_valid, out_data, out_ch, m_valid, m_data, m_ch); end
      end
   endtask

   initial begin
      rst = 1; mode = 0; in_valid = 0; out_ready = 0;
      for (int i = 0; i < N; i++) hd[i] = '0;
      m_reset();
      repeat (2) @(posedge clk);
      #1 rst = 0;
      test_reset();
      test_single();
      test_rr_fair();
      test_fixed();
      test_backpressure();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
